// File: rtl/dds_channel_scheduler.sv
// dds_channel_scheduler
// Shares one DDS core between NUM_CH NCO channels. Each cycle the
// first enabled channel at or after the round-robin pointer sends
// acc+ofs to the DDS, and its channel id is pushed into a tag FIFO.
// DDS results come back in order. Each result pops one tag, and the
// pair {tag, sample} goes into the output FIFO. Issue stops while the
// tag FIFO and the output FIFO together hold FIFO_DEPTH entries, so the
// output FIFO never overflows even though the DDS cannot be stalled.
// Optional feature macro: DDS_SCHED_COS_EN. When it is defined, a cos
// sample is stored next to each sin sample.
module dds_channel_scheduler #(
    parameter int  PHASE_DW   = 16,
    parameter int  OUT_DW     = 16,
    parameter int  NUM_CH     = 4,
    parameter int  FIFO_DEPTH = 8,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_wr_en,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PHASE_DW-1:0] cfg_phase_inc,
    input  logic [PHASE_DW-1:0] cfg_phase_ofs,
    input  logic [NUM_CH-1:0]   ch_enable,
    input  logic                sync_clear,
    output logic [PHASE_DW-1:0] m_axis_dds_phase_tdata,
    output logic                m_axis_dds_phase_tvalid,
    input  logic [OUT_DW-1:0]   s_axis_dds_sin_tdata,
    input  logic                s_axis_dds_sin_tvalid,
`ifdef DDS_SCHED_COS_EN
    input  logic [OUT_DW-1:0]   s_axis_dds_cos_tdata,
    output logic [OUT_DW-1:0]   m_axis_ch_cos_tdata,
`endif
    output logic [OUT_DW-1:0]   m_axis_ch_tdata,
    output logic [CH_W-1:0]     m_axis_ch_tuser,
    output logic                m_axis_ch_tvalid,
    input  logic                m_axis_ch_tready,
    output logic                err_tag
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              CNT_W     = AW + 1;
    localparam logic [CNT_W:0]  DEPTH_SUM = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    // Per-channel NCO state
    logic [PHASE_DW-1:0] r_acc [NUM_CH];
    logic [PHASE_DW-1:0] r_inc [NUM_CH];
    logic [PHASE_DW-1:0] r_ofs [NUM_CH];
    logic [CH_W-1:0]     r_ptr;
    logic [PHASE_DW-1:0] r_phase;
    logic                r_phase_vld;

    // Tag FIFO: channel ids of requests that are still inside the DDS
    logic [CH_W-1:0]     r_tag_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_tag_wr;
    logic [AW-1:0]       r_tag_rd;
    logic [CNT_W-1:0]    r_tag_cnt;

    // Output FIFO: {channel, sample} pairs waiting for the downstream
    logic [OUT_DW-1:0]   r_out_dat [FIFO_DEPTH];
    logic [CH_W-1:0]     r_out_ch  [FIFO_DEPTH];
`ifdef DDS_SCHED_COS_EN
    logic [OUT_DW-1:0]   r_out_cos [FIFO_DEPTH];
`endif
    logic [AW-1:0]       r_out_wr;
    logic [AW-1:0]       r_out_rd;
    logic [CNT_W-1:0]    r_out_cnt;
    logic                r_err;

    logic                w_any_en;
    logic [CH_W-1:0]     w_sel;
    logic [CH_W-1:0]     w_ptr_next;
    logic [CNT_W:0]      w_used;
    logic                w_issue;
    logic                w_tag_empty;
    logic                w_tag_pop;
    logic                w_out_vld;
    logic                w_out_full;
    logic                w_out_pop;
    logic                w_out_push;

    // Round-robin pick: the first enabled channel at or after r_ptr
    // NOTE: always_comb outputs get a default first, so no path leaves them unassigned and no latch is inferred.
    always_comb begin
        w_any_en = 1'b0;
        w_sel    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!w_any_en && ch_enable[CH_W'((int'(r_ptr) + k) % NUM_CH)]) begin
                w_any_en = 1'b1;
                w_sel    = CH_W'((int'(r_ptr) + k) % NUM_CH);
            end
        end
    end

    assign w_ptr_next  = (w_sel == CH_W'(NUM_CH - 1)) ? '0 : w_sel + CH_W'(1);
    assign w_used      = {1'b0, r_tag_cnt} + {1'b0, r_out_cnt};
    assign w_issue     = w_any_en && (w_used < DEPTH_SUM);
    assign w_tag_empty = (r_tag_cnt == '0);
    assign w_tag_pop   = s_axis_dds_sin_tvalid && !w_tag_empty;
    assign w_out_vld   = (r_out_cnt != '0);
    assign w_out_full  = (r_out_cnt == DEPTH_CNT);
    assign w_out_pop   = w_out_vld && m_axis_ch_tready;
    assign w_out_push  = w_tag_pop && (!w_out_full || w_out_pop);

    // Phase issue, accumulator advance, config writes and sync clear
    // NOTE: sequential state uses non-blocking assignments, so every read in this block sees the pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
                r_inc[i] <= '0;
                r_ofs[i] <= '0;
            end
            r_ptr       <= '0;
            r_phase     <= '0;
            r_phase_vld <= 1'b0;
        end else begin
            r_phase_vld <= w_issue;
            if (w_issue) begin
                r_phase      <= r_acc[w_sel] + r_ofs[w_sel];
                r_acc[w_sel] <= r_acc[w_sel] + r_inc[w_sel];
                r_ptr        <= w_ptr_next;
            end
            // Later assignment wins, so a clear overrides this cycle's accumulate
            if (sync_clear) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_acc[i] <= '0;
                end
            end
            if (cfg_wr_en) begin
                r_inc[cfg_ch] <= cfg_phase_inc;
                r_ofs[cfg_ch] <= cfg_phase_ofs;
            end
        end
    end

    // Tag FIFO pointers and occupancy; push on issue, pop on DDS result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tag_wr  <= '0;
            r_tag_rd  <= '0;
            r_tag_cnt <= '0;
        end else begin
            if (w_issue) begin
                r_tag_wr <= r_tag_wr + AW'(1);
            end
            if (w_tag_pop) begin
                r_tag_rd <= r_tag_rd + AW'(1);
            end
            case ({w_issue, w_tag_pop})
                2'b10:   r_tag_cnt <= r_tag_cnt + CNT_W'(1);
                2'b01:   r_tag_cnt <= r_tag_cnt - CNT_W'(1);
                default: r_tag_cnt <= r_tag_cnt;
            endcase
        end
    end

    // Tag FIFO storage
    // NOTE: FIFO storage is not reset; occupancy counters decide what is valid, and outputs are gated by them.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_tag_mem[r_tag_wr] <= w_sel;
        end
    end

    // Output FIFO pointers, occupancy and the sticky orphan-result flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_wr  <= '0;
            r_out_rd  <= '0;
            r_out_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_out_push) begin
                r_out_wr <= r_out_wr + AW'(1);
            end
            if (w_out_pop) begin
                r_out_rd <= r_out_rd + AW'(1);
            end
            case ({w_out_push, w_out_pop})
                2'b10:   r_out_cnt <= r_out_cnt + CNT_W'(1);
                2'b01:   r_out_cnt <= r_out_cnt - CNT_W'(1);
                default: r_out_cnt <= r_out_cnt;
            endcase
            if (s_axis_dds_sin_tvalid && w_tag_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // Output FIFO storage: the sample is paired with the channel tag it popped
    always_ff @(posedge clk) begin
        if (w_out_push) begin
            r_out_dat[r_out_wr] <= s_axis_dds_sin_tdata;
            r_out_ch[r_out_wr]  <= r_tag_mem[r_tag_rd];
`ifdef DDS_SCHED_COS_EN
            r_out_cos[r_out_wr] <= s_axis_dds_cos_tdata;
`endif
        end
    end

    assign m_axis_dds_phase_tdata  = r_phase;
    assign m_axis_dds_phase_tvalid = r_phase_vld;
    assign m_axis_ch_tvalid        = w_out_vld;
    assign m_axis_ch_tdata         = w_out_vld ? r_out_dat[r_out_rd] : '0;
    assign m_axis_ch_tuser         = w_out_vld ? r_out_ch[r_out_rd]  : '0;
`ifdef DDS_SCHED_COS_EN
    assign m_axis_ch_cos_tdata     = w_out_vld ? r_out_cos[r_out_rd] : '0;
`endif
    assign err_tag                 = r_err;

endmodule
